// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryption engine: one combinational round per clock,
// valid/ready handshakes on the plaintext side and the ciphertext side.

package aes128_pkg;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254, maps 0 to 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] pw;
        inv = 8'h01;
        pw  = x;
        for (int i = 1; i < 8; i++) begin
            pw  = gmul(pw, pw);
            inv = gmul(inv, pw);
        end
        return inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
    endfunction

endpackage

// SubBytes over the full 128-bit state
module substitutebyte (
    input  logic [127:0] data_i,
    output logic [127:0] data_o
);
    import aes128_pkg::*;

    // Byte-wise S-box substitution
    always_comb begin
        data_o = '0;
        for (int i = 0; i < 16; i++) begin
            data_o[127-8*i -: 8] = sbox(data_i[127-8*i -: 8]);
        end
    end
endmodule

// ShiftRows: byte i sits at row i%4, column i/4; row r rotates left by r
module shiftrow (
    input  logic [127:0] data_i,
    output logic [127:0] data_o
);
    // Pure byte permutation
    always_comb begin
        data_o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                data_o[127-8*(4*c+r) -: 8] = data_i[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
    end
endmodule

// One full AES round plus the next round key derived from key_i and round index rc_i
module round (
    input  logic [127:0] data_i,
    input  logic [127:0] key_i,
    input  logic [3:0]   rc_i,
    output logic [127:0] out_o,
    output logic [127:0] keyout_o
);
    import aes128_pkg::*;

    logic [127:0] sb;
    logic [127:0] sr;
    logic [127:0] mc;
    logic [7:0]   rcon;
    logic [31:0]  w0, w1, w2, w3, tmp;

    substitutebyte u_sb (.data_i(data_i), .data_o(sb));
    shiftrow       u_sr (.data_i(sb),     .data_o(sr));

    // MixColumns on each 32-bit column
    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        mc = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = sr[127-32*c -: 8];
            a1 = sr[119-32*c -: 8];
            a2 = sr[111-32*c -: 8];
            a3 = sr[103-32*c -: 8];
            mc[127-32*c -: 8] = xtime(a0) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            mc[119-32*c -: 8] = a0 ^ xtime(a1) ^ gmul(a2, 8'h03) ^ a3;
            mc[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ gmul(a3, 8'h03);
            mc[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ xtime(a3);
        end
    end

    // Round constant for round index 1..10
    always_comb begin
        case (rc_i)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // Key expansion step: RotWord, SubWord, Rcon, then the chained XORs
    always_comb begin
        w0  = key_i[127:96];
        w1  = key_i[95:64];
        w2  = key_i[63:32];
        w3  = key_i[31:0];
        tmp = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        keyout_o[127:96] = w0 ^ tmp;
        keyout_o[95:64]  = w1 ^ w0 ^ tmp;
        keyout_o[63:32]  = w2 ^ w1 ^ w0 ^ tmp;
        keyout_o[31:0]   = w3 ^ w2 ^ w1 ^ w0 ^ tmp;
    end

    assign out_o = mc ^ keyout_o;
endmodule

module aes128_encrypt_iter #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] pt,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ct
);
    localparam logic [3:0] NR_C = 4'(NR);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   rcnt_q, rcnt_d;
    logic [127:0] ct_q, ct_d;

    logic [127:0] r_out;
    logic [127:0] r_keyout;
    logic [127:0] fin_sb;
    logic [127:0] fin_sr;

    round u_round (
        .data_i   (st_q),
        .key_i    (rk_q),
        .rc_i     (rcnt_q),
        .out_o    (r_out),
        .keyout_o (r_keyout)
    );

    // Last round skips MixColumns; its key still comes from the round's key schedule
    substitutebyte u_fin_sb (.data_i(st_q),   .data_o(fin_sb));
    shiftrow       u_fin_sr (.data_i(fin_sb), .data_o(fin_sr));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (rcnt_q >= NR_C) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state only
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Datapath next-state: initial AddRoundKey, full rounds, then the final round into ct
    always_comb begin
        st_d   = st_q;
        rk_d   = rk_q;
        rcnt_d = rcnt_q;
        ct_d   = ct_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    st_d   = pt ^ key;
                    rk_d   = key;
                    rcnt_d = 4'd1;
                end
            end
            RUN: begin
                if (rcnt_q < NR_C) begin
                    st_d   = r_out;
                    rk_d   = r_keyout;
                    rcnt_d = rcnt_q + 4'd1;
                end else begin
                    ct_d = r_keyout ^ fin_sr;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= '0;
            rk_q   <= '0;
            rcnt_q <= '0;
            ct_q   <= '0;
        end else begin
            st_q   <= st_d;
            rk_q   <= rk_d;
            rcnt_q <= rcnt_d;
            ct_q   <= ct_d;
        end
    end

    assign ct = ct_q;
endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Testbench for aes128_encrypt_iter: FIPS-197 vectors, handshake scenarios,
// reset behaviour and random vectors against a byte-array AES reference model.

module tb_aes128_encrypt_iter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] pt;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ct;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    always #5 clk = ~clk;

    aes128_encrypt_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pt        (pt),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ct        (ct)
    );

    function automatic logic [7:0] xt(input logic [7:0] b);
        return (b[7]) ? ((b << 1) ^ 8'h1b) : (b << 1);
    endfunction

    // Reference AES-128 on byte arrays: full key expansion up front, then 10 rounds
    function automatic logic [127:0] aes_ref(input logic [127:0] p, input logic [127:0] k);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   w [176];
        logic [7:0]   tmp [4];
        logic [7:0]   rc, hold, all;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            s[i] = p[127-8*i -: 8];
            w[i] = k[127-8*i -: 8];
        end
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
            if (i % 16 == 0) begin
                hold   = tmp[0];
                tmp[0] = SBOX[tmp[1]] ^ rc;
                tmp[1] = SBOX[tmp[2]];
                tmp[2] = SBOX[tmp[3]];
                tmp[3] = SBOX[hold];
                rc     = xt(rc);
            end
            for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = SBOX[s[(i + 4*(i%4)) % 16]];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    all = t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c]   = t[4*c]   ^ all ^ xt(t[4*c]   ^ t[4*c+1]);
                    s[4*c+1] = t[4*c+1] ^ all ^ xt(t[4*c+1] ^ t[4*c+2]);
                    s[4*c+2] = t[4*c+2] ^ all ^ xt(t[4*c+2] ^ t[4*c+3]);
                    s[4*c+3] = t[4*c+3] ^ all ^ xt(t[4*c+3] ^ t[4*c]);
                end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Present one vector while idle; scramble pt/key right after the accept edge
    task automatic accept(input logic [127:0] p, input logic [127:0] k);
        pt = p;
        key = k;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        pt  = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Edges from the accept edge until out_valid is seen (bounded at 40)
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!out_valid && n < 40);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        pt = '0;
        key = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (ct !== 128'h0) begin errors++; $display("FAIL reset_ct got=%h exp=0", ct); end
        rst_n = 1'b1;
    endtask

    task automatic test_idle_hold;
        out_ready = 1'b1;
        in_valid = 1'b0;
        pt = PT_B;
        key = KEY_B;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || ct !== 128'h0) begin
                errors++; $display("FAIL idle_hold cycle=%0d out_valid=%b in_ready=%b ct=%h exp 0/1/0", i, out_valid, in_ready, ct);
            end
        end
    endtask

    task automatic test_fips_b;
        int n;
        out_ready = 1'b1;
        accept(PT_B, KEY_B);
        wait_valid(n);
        checks++; if (n !== 10) begin errors++; $display("FAIL fips_b_latency got=%0d exp=10", n); end
        checks++; if (ct !== CT_B) begin errors++; $display("FAIL fips_b_ct got=%h exp=%h", ct, CT_B); end
        checks++; if (ct !== aes_ref(PT_B, KEY_B)) begin errors++; $display("FAIL fips_b_model got=%h exp=%h", ct, aes_ref(PT_B, KEY_B)); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL fips_b_pulse out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
        end
        checks++; if (ct !== CT_B) begin errors++; $display("FAIL fips_b_ct_hold got=%h exp=%h", ct, CT_B); end
    endtask

    task automatic test_fips_c1;
        int n;
        out_ready = 1'b1;
        accept(PT_C, KEY_C);
        wait_valid(n);
        checks++; if (n !== 10) begin errors++; $display("FAIL fips_c1_latency got=%0d exp=10", n); end
        checks++; if (ct !== CT_C) begin errors++; $display("FAIL fips_c1_ct got=%h exp=%h", ct, CT_C); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fips_c1_pulse out_valid=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure;
        int n;
        out_ready = 1'b0;
        accept(PT_B, KEY_B);
        wait_valid(n);
        checks++; if (n !== 10) begin errors++; $display("FAIL bp_latency got=%0d exp=10", n); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || ct !== CT_B) begin
                errors++; $display("FAIL bp_hold cycle=%0d out_valid=%b in_ready=%b ct=%h exp 1/0/%h", i, out_valid, in_ready, ct, CT_B);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_busy_ignore;
        int edge_n [$];
        logic [127:0] cts [$];
        int n;
        out_ready = 1'b1;
        pt = PT_B;
        key = KEY_B;
        in_valid = 1'b1;
        @(posedge clk); #1;
        pt = PT_C;
        key = KEY_C;
        n = 0;
        while (n < 23) begin
            @(posedge clk); #1;
            n++;
            if (out_valid) begin
                edge_n.push_back(n);
                cts.push_back(ct);
            end
        end
        in_valid = 1'b0;
        checks++; if (edge_n.size() !== 2) begin errors++; $display("FAIL busy_count got=%0d exp=2", edge_n.size()); end
        if (edge_n.size() >= 1) begin
            checks++; if (edge_n[0] !== 10 || cts[0] !== CT_B) begin
                errors++; $display("FAIL busy_first edge=%0d ct=%h exp edge=10 ct=%h", edge_n[0], cts[0], CT_B);
            end
        end
        if (edge_n.size() >= 2) begin
            checks++; if (edge_n[1] !== 22 || cts[1] !== CT_C) begin
                errors++; $display("FAIL busy_second edge=%0d ct=%h exp edge=22 ct=%h", edge_n[1], cts[1], CT_C);
            end
        end
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL busy_idle in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_run;
        int n;
        out_ready = 1'b1;
        accept(PT_B, KEY_B);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || ct !== 128'h0) begin
            errors++; $display("FAIL mid_reset_async out_valid=%b in_ready=%b ct=%h exp 0/1/0", out_valid, in_ready, ct);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || ct !== 128'h0) begin
                errors++; $display("FAIL mid_reset_hold cycle=%0d out_valid=%b in_ready=%b ct=%h exp 0/1/0", i, out_valid, in_ready, ct);
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset_release out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
        end
        accept(PT_C, KEY_C);
        wait_valid(n);
        checks++; if (n !== 10) begin errors++; $display("FAIL mid_reset_latency got=%0d exp=10", n); end
        checks++; if (ct !== CT_C) begin errors++; $display("FAIL mid_reset_ct got=%h exp=%h", ct, CT_C); end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        logic [127:0] p, k, exp;
        int n, stall;
        for (int it = 0; it < 8; it++) begin
            p = {$urandom, $urandom, $urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            exp = aes_ref(p, k);
            stall = $urandom_range(0, 3);
            out_ready = 1'b0;
            accept(p, k);
            wait_valid(n);
            checks++; if (n !== 10 || ct !== exp) begin
                errors++; $display("FAIL random_%0d latency=%0d ct=%h exp latency=10 ct=%h", it, n, ct, exp);
            end
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                checks++; if (out_valid !== 1'b1 || ct !== exp) begin
                    errors++; $display("FAIL random_stall_%0d out_valid=%b ct=%h exp 1/%h", it, out_valid, ct, exp);
                end
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || ct !== exp) begin
                errors++; $display("FAIL random_done_%0d out_valid=%b in_ready=%b ct=%h exp 0/1/%h", it, out_valid, in_ready, ct, exp);
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_hold();
        test_fips_b();
        test_fips_c1();
        test_backpressure();
        test_busy_ignore();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
